// File: rtl/hz_quad_router_if.sv
// Bundled quad-in, HZ query/verdict and two-path output signals of hz_quad_router.
// master = the router side, slave = the quad source / HZ unit / downstream consumers.
interface hz_quad_router_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH_W    = 16,
  parameter int PAYLOAD_W  = 32,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_tile;
  logic [DEPTH_W-1:0]    in_zmin;
  logic [PAYLOAD_W-1:0]  in_payload;
  logic                  hz_query_valid;
  logic [ADDR_WIDTH-1:0] hz_tile_addr;
  logic [DEPTH_W-1:0]    hz_in_depth;
  logic [1:0]            hz_verdict;
  logic                  hz_verdict_valid;
  logic                  fast_valid;
  logic                  fast_ready;
  logic [PAYLOAD_W-1:0]  fast_payload;
  logic                  ez_valid;
  logic                  ez_ready;
  logic [PAYLOAD_W-1:0]  ez_payload;
  logic [CNT_W-1:0]      cnt_reject;
  logic [CNT_W-1:0]      cnt_pass;
  logic [CNT_W-1:0]      cnt_unknown;
  logic                  verdict_err;

  modport master (
    input  in_valid, in_tile, in_zmin, in_payload, hz_verdict, hz_verdict_valid,
           fast_ready, ez_ready,
    output in_ready, hz_query_valid, hz_tile_addr, hz_in_depth, fast_valid, fast_payload,
           ez_valid, ez_payload, cnt_reject, cnt_pass, cnt_unknown, verdict_err
  );

  modport slave (
    output in_valid, in_tile, in_zmin, in_payload, hz_verdict, hz_verdict_valid,
           fast_ready, ez_ready,
    input  in_ready, hz_query_valid, hz_tile_addr, hz_in_depth, fast_valid, fast_payload,
           ez_valid, ez_payload, cnt_reject, cnt_pass, cnt_unknown, verdict_err
  );
endinterface

// File: rtl/hz_quad_router.sv
// Issues one HZ query per accepted quad, parks quads in an in-order pending FIFO and
// routes each by its verdict: reject drops, pass goes to the fast path, unknown to early-Z.
module hz_quad_router #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH_W    = 16,
  parameter int PAYLOAD_W  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hz_quad_router_if.master     bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Three wrap-bit pointers: wr (next free), rs (oldest unresolved), rd (head).
  logic [AW:0] wr, rs, rd;
  logic [PAYLOAD_W-1:0] pay_mem [FIFO_DEPTH];
  logic [1:0]           cls_mem [FIFO_DEPTH];

  logic                  q_valid;
  logic [ADDR_WIDTH-1:0] q_tile;
  logic [DEPTH_W-1:0]    q_depth;
  logic [CNT_W-1:0]      c_rej, c_pas, c_unk;
  logic                  err;

  logic       full, accept, outstanding, vld, head_rdy, pop;
  logic [1:0] vcls, head_cls;

  assign full        = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign accept      = bus.in_valid && !full;
  assign outstanding = (rs != wr);
  assign vld         = bus.hz_verdict_valid && outstanding;
  assign vcls        = (bus.hz_verdict == 2'b11) ? 2'b10 : bus.hz_verdict;
  assign head_rdy    = (rd != rs);
  assign head_cls    = cls_mem[rd[AW-1:0]];

  assign bus.in_ready       = !full;
  assign bus.hz_query_valid = q_valid;
  assign bus.hz_tile_addr   = q_tile;
  assign bus.hz_in_depth    = q_depth;
  assign bus.fast_valid     = head_rdy && (head_cls == 2'b01);
  assign bus.ez_valid       = head_rdy && (head_cls == 2'b10);
  assign bus.fast_payload   = pay_mem[rd[AW-1:0]];
  assign bus.ez_payload     = pay_mem[rd[AW-1:0]];
  assign bus.cnt_reject     = c_rej;
  assign bus.cnt_pass       = c_pas;
  assign bus.cnt_unknown    = c_unk;
  assign bus.verdict_err    = err;

  // Rejected heads leave without a handshake so they never stall the queue.
  assign pop = head_rdy && ((head_cls == 2'b00) ||
                            (bus.fast_valid && bus.fast_ready) ||
                            (bus.ez_valid && bus.ez_ready));

  always_ff @(posedge clk) begin
    if (accept) pay_mem[wr[AW-1:0]] <= bus.in_payload;
    if (vld)    cls_mem[rs[AW-1:0]] <= vcls;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr      <= '0;
      rs      <= '0;
      rd      <= '0;
      q_valid <= 1'b0;
      q_tile  <= '0;
      q_depth <= '0;
      c_rej   <= '0;
      c_pas   <= '0;
      c_unk   <= '0;
      err     <= 1'b0;
    end else begin
      q_valid <= accept;
      if (accept) begin
        wr      <= wr + PTR_ONE;
        q_tile  <= bus.in_tile;
        q_depth <= bus.in_zmin;
      end
      if (vld) begin
        rs <= rs + PTR_ONE;
        unique case (vcls)
          2'b00:   c_rej <= c_rej + CNT_ONE;
          2'b01:   c_pas <= c_pas + CNT_ONE;
          default: c_unk <= c_unk + CNT_ONE;
        endcase
      end
      // Illegal code or a verdict with nothing in flight both flag a protocol error.
      if (bus.hz_verdict_valid && (!outstanding || bus.hz_verdict == 2'b11))
        err <= 1'b1;
      if (pop) rd <= rd + PTR_ONE;
    end
  end
endmodule
